// File: rtl/uart_pkg.sv
// Shared state type, legal parameter ranges and bit-timing helper for the oversampled UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

    localparam int unsigned DATA_BITS_MIN    = 5;
    localparam int unsigned DATA_BITS_MAX    = 9;
    localparam int unsigned STOP_BITS_MIN    = 1;
    localparam int unsigned STOP_BITS_MAX    = 2;
    localparam int unsigned CLKS_PER_BIT_MIN = 4;
    localparam int unsigned SYNC_STAGES_MIN  = 2;

    // Start-bit sample point, in rx_clk cycles after the falling edge is seen.
    function automatic int unsigned uart_half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; flops reset to the idle level (1).
module uart_sync
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic rx_clk,
    input  logic rx_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_sync;

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
        $error("uart_sync: SYNC_STAGES must be at least 2");
    end

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: start-glitch rejection, framing/parity/break reporting.
// Define UART_RX_PARITY_EN to expect one parity bit between the data and stop bits.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 rx_clk,
    input  logic                 rx_rst_n,
    input  logic                 rx_serial_data,
    output logic [DATA_BITS-1:0] rx_parallel_data,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_break
);

    localparam int unsigned      HALF_BIT  = uart_half_bit(CLKS_PER_BIT);
    localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CLKS_PER_BIT);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
        $error("uart_rx_oversampled: DATA_BITS must be 5..9");
    end
    if (CLKS_PER_BIT < CLKS_PER_BIT_MIN) begin : g_bad_clks_per_bit
        $error("uart_rx_oversampled: CLKS_PER_BIT must be at least 4");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
        $error("uart_rx_oversampled: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("uart_rx_oversampled: PARITY_ODD must be 0 or 1");
    end

    uart_rx_state_t       r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [3:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_stop_err;
    logic                 r_stop_hi;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_frame_err;
    logic                 r_break;
    logic                 w_s_rx;
    logic                 w_stop_err;
    logic                 w_par_low;
    logic                 w_break;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .rx_clk   (rx_clk),
        .rx_rst_n (rx_rst_n),
        .i_d      (rx_serial_data),
        .o_q      (w_s_rx)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    logic r_parity_err;
    logic w_par_err;

    assign w_par_low     = ~r_par_bit;
    assign w_par_err     = ((^r_shift) ^ r_par_bit) != 1'(PARITY_ODD);
    assign rx_parity_err = r_parity_err;
`else
    assign w_par_low     = 1'b1;
    assign rx_parity_err = 1'b0;
`endif

    // Evaluated on the final stop sample, so the current s_rx counts as one of the stop bits.
    assign w_stop_err = r_stop_err | ~w_s_rx;
    assign w_break    = (r_shift == '0) & w_par_low & ~r_stop_hi & ~w_s_rx;

    always_ff @(posedge rx_clk or negedge rx_rst_n) begin
        if (!rx_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_stop_err  <= 1'b0;
            r_stop_hi   <= 1'b0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_break     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (!w_s_rx) begin
                        r_state    <= START;
                        r_cnt      <= CNT_ONE;
                        r_idx      <= '0;
                        r_stop_err <= 1'b0;
                        r_stop_hi  <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= CNT_ONE;
                        if (w_s_rx) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt   <= CNT_ONE;
                        r_shift <= {w_s_rx, r_shift[DATA_BITS-1:1]};
                        if (r_idx == DATA_LAST) begin
                            r_idx <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt     <= CNT_ONE;
                        r_par_bit <= w_s_rx;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
`endif
                STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt      <= CNT_ONE;
                        r_stop_err <= w_stop_err;
                        r_stop_hi  <= r_stop_hi | w_s_rx;
                        if (r_idx == STOP_LAST) begin
                            r_state     <= w_s_rx ? IDLE : WAIT_HIGH;
                            r_data      <= r_shift;
                            r_frame_err <= w_stop_err;
                            r_break     <= w_break;
                            r_done      <= 1'b1;
                            r_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= w_par_err;
`endif
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (w_s_rx) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_parallel_data = r_data;
    assign rx_done          = r_done;
    assign rx_busy          = r_busy;
    assign rx_frame_err     = r_frame_err;
    assign rx_break         = r_break;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled: directed and random frames against a frame-level model.
// Adds the parity-error cases when UART_RX_PARITY_EN is defined.
module tb_uart_rx_oversampled;

    localparam int unsigned CPB   = 16;
    localparam int unsigned DBITS = 8;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PAR_EN = 1;
`else
    localparam int unsigned PAR_EN = 0;
`endif
    localparam int FRAME_CYC = int'(CPB * (DBITS + 2 + PAR_EN));

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        logic       br;
        int         cyc;
    } rec_t;

    logic       rx_clk         = 1'b0;
    logic       rx_rst_n       = 1'b0;
    logic       rx_serial_data = 1'b1;
    logic [7:0] rx_parallel_data;
    logic       rx_done;
    logic       rx_busy;
    logic       rx_frame_err;
    logic       rx_parity_err;
    logic       rx_break;

    rec_t q[$];
    int   cyc        = 0;
    int   checks     = 0;
    int   errors     = 0;
    int   dbl_done   = 0;
    int   done_cnt   = 0;
    int   busy_rises = 0;
    int   nframes    = 0;
    int   last_cyc   = 0;
    logic prev_done  = 1'b0;
    logic prev_busy  = 1'b0;

    uart_rx_oversampled dut (
        .rx_clk           (rx_clk),
        .rx_rst_n         (rx_rst_n),
        .rx_serial_data   (rx_serial_data),
        .rx_parallel_data (rx_parallel_data),
        .rx_done          (rx_done),
        .rx_busy          (rx_busy),
        .rx_frame_err     (rx_frame_err),
        .rx_parity_err    (rx_parity_err),
        .rx_break         (rx_break)
    );

    always #5 rx_clk = ~rx_clk;

    always @(posedge rx_clk) cyc <= cyc + 1;

    always @(negedge rx_clk) begin
        if (rx_done) begin
            q.push_back('{rx_parallel_data, rx_frame_err, rx_parity_err, rx_break, cyc});
            done_cnt = done_cnt + 1;
        end
        if (rx_done && prev_done) dbl_done = dbl_done + 1;
        if (rx_busy && !prev_busy) busy_rises = busy_rises + 1;
        prev_done = rx_done;
        prev_busy = rx_busy;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: what one frame should report, from the line-level values that were sent.
    function automatic rec_t model(input logic [7:0] d, input logic stop, input logic par);
        rec_t r;
        r.data = d;
        r.fe   = ~stop;
        r.pe   = (PAR_EN != 0) && (((^d) ^ par) != 1'b0);
        r.br   = (d == 8'h00) && !stop && ((PAR_EN == 0) || !par);
        r.cyc  = 0;
        return r;
    endfunction

    task automatic send_bit(input logic v);
        rx_serial_data = v;
        repeat (CPB) @(negedge rx_clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_bit(1'b0);
        for (int i = 0; i < int'(DBITS); i++) send_bit(d[i]);
        if (PAR_EN != 0) send_bit(par);
        send_bit(stop);
    endtask

    task automatic expect_frame(input string tag, input rec_t e);
        rec_t r;
        int   n;
        n = 0;
        nframes++;
        while (q.size() == 0 && n < 2 * FRAME_CYC) begin
            @(negedge rx_clk);
            n++;
        end
        check({tag, ".present"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            r        = q.pop_front();
            last_cyc = r.cyc;
            check({tag, ".data"}, 32'(r.data), 32'(e.data));
            check({tag, ".frame_err"}, 32'(r.fe), 32'(e.fe));
            check({tag, ".parity_err"}, 32'(r.pe), 32'(e.pe));
            check({tag, ".break"}, 32'(r.br), 32'(e.br));
        end
    endtask

    initial begin
        int         t0;
        int         c1;
        int         b0;
        logic [7:0] d;
        logic       stop;
        logic       par;

        repeat (3) @(negedge rx_clk);
        check("rst.data", 32'(rx_parallel_data), 32'd0);
        check("rst.done", 32'(rx_done), 32'd0);
        check("rst.busy", 32'(rx_busy), 32'd0);
        check("rst.frame_err", 32'(rx_frame_err), 32'd0);
        check("rst.parity_err", 32'(rx_parity_err), 32'd0);
        check("rst.break", 32'(rx_break), 32'd0);
        rx_rst_n = 1'b1;
        repeat (2 * CPB) @(negedge rx_clk);

        // Clean frame; done must land near the end of the stop bit.
        t0 = cyc;
        send_frame(8'hA5, 1'b1, ^8'hA5);
        expect_frame("a5", model(8'hA5, 1'b1, ^8'hA5));
        check("a5.latency", 32'((last_cyc - t0) >= FRAME_CYC - 10 && (last_cyc - t0) <= FRAME_CYC + 5),
              32'd1);

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, ^8'hFF);
        send_bit(1'b1);
        expect_frame("b2b0", model(8'h00, 1'b1, 1'b0));
        c1 = last_cyc;
        expect_frame("b2b1", model(8'hFF, 1'b1, ^8'hFF));
        check("b2b.gap", 32'(last_cyc - c1), 32'(FRAME_CYC));

        // Start-bit glitch.
        b0 = busy_rises;
        rx_serial_data = 1'b0;
        repeat (4) @(negedge rx_clk);
        rx_serial_data = 1'b1;
        repeat (2 * CPB) @(negedge rx_clk);
        check("glitch.no_done", 32'(q.size()), 32'd0);
        check("glitch.busy_pulse", 32'(busy_rises - b0), 32'd1);
        check("glitch.busy_now", 32'(rx_busy), 32'd0);
        check("glitch.data_held", 32'(rx_parallel_data), 32'hFF);

        // Stop bit 0 with the line held low afterwards.
        send_frame(8'h3C, 1'b0, ^8'h3C);
        b0 = busy_rises;
        repeat (3 * CPB) @(negedge rx_clk);
        check("fe.single", 32'(q.size()), 32'd1);
        check("fe.wait_busy", 32'(rx_busy), 32'd0);
        check("fe.no_restart", 32'(busy_rises - b0), 32'd0);
        rx_serial_data = 1'b1;
        repeat (2 * CPB) @(negedge rx_clk);
        expect_frame("fe", model(8'h3C, 1'b0, ^8'h3C));

        // Break: line low for 20 bit times.
        rx_serial_data = 1'b0;
        repeat (12 * CPB) @(negedge rx_clk);
        check("brk.one_frame", 32'(q.size()), 32'd1);
        check("brk.busy_low", 32'(rx_busy), 32'd0);
        b0 = busy_rises;
        repeat (8 * CPB) @(negedge rx_clk);
        rx_serial_data = 1'b1;
        repeat (2 * CPB) @(negedge rx_clk);
        check("brk.still_one", 32'(q.size()), 32'd1);
        check("brk.no_restart", 32'(busy_rises - b0), 32'd0);
        expect_frame("brk", model(8'h00, 1'b0, 1'b0));

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        expect_frame("par.good", model(8'h07, 1'b1, 1'b1));
        send_frame(8'h07, 1'b1, 1'b0);
        expect_frame("par.bad", model(8'h07, 1'b1, 1'b0));
`endif

        // Asynchronous reset in the middle of the data bits.
        send_frame(8'hC3, 1'b1, ^8'hC3);
        expect_frame("pre_rst", model(8'hC3, 1'b1, ^8'hC3));
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("rst_mid.busy_before", 32'(rx_busy), 32'd1);
        #2 rx_rst_n = 1'b0;
        #1;
        check("rst_mid.data", 32'(rx_parallel_data), 32'd0);
        check("rst_mid.busy", 32'(rx_busy), 32'd0);
        check("rst_mid.done", 32'(rx_done), 32'd0);
        check("rst_mid.frame_err", 32'(rx_frame_err), 32'd0);
        check("rst_mid.break", 32'(rx_break), 32'd0);
        rx_serial_data = 1'b1;
        repeat (CPB) @(negedge rx_clk);
        rx_rst_n = 1'b1;
        repeat (2 * CPB) @(negedge rx_clk);
        check("rst_mid.no_done", 32'(q.size()), 32'd0);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        expect_frame("post_rst", model(8'h5A, 1'b1, ^8'h5A));

        // Random frames; a bad stop bit is followed by one idle bit so the line returns high.
        for (int i = 0; i < 8; i++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            par  = 1'($urandom_range(0, 1));
            send_frame(d, stop, par);
            if (!stop) send_bit(1'b1);
            expect_frame($sformatf("rnd%0d", i), model(d, stop, par));
        end

        repeat (2 * CPB) @(negedge rx_clk);
        check("done.single_cycle", 32'(dbl_done), 32'd0);
        check("done.count", 32'(done_cnt), 32'(nframes));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
